// File: rtl/s_mem_pkg.sv
// Shared definitions for the RC4 S-array memory responder.
//   - s_mem_state_e  : responder FSM states (initializing / ready)
//   - DEFAULT_ADDR_W : default address width (depth = 2^ADDR_W)
//   - DEFAULT_DATA_W : default data width
//   - MAX_RD_LATENCY : deepest read pipeline an initiator can tolerate
package s_mem_pkg;

    localparam int unsigned DEFAULT_ADDR_W = 8;
    localparam int unsigned DEFAULT_DATA_W = 8;

    // Initiators sample read data 3 edges after driving the address.
    localparam int unsigned MAX_RD_LATENCY = 3;

    typedef enum logic {
        StInit  = 1'b0,
        StReady = 1'b1
    } s_mem_state_e;

endpackage

// File: rtl/s_mem_rd_pipe.sv
// Free-running read-data shift register.
// Ports:
//   clk   in   clock, rising edge
//   reset in   synchronous active-high reset, clears every stage
//   din   in   DATA_W  data captured into the first stage every edge
//   dout  out  DATA_W  last stage, DEPTH edges after din was captured
module s_mem_rd_pipe #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] stage_q [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/s_memory_responder.sv
// Memory-side responder holding the RC4 S-array. After reset (or on
// init_start while ready) it writes S[i] = i to every location, then raises
// ready and serves single-port byte accesses.
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset
//   addr_mem   in   ADDR_W  access address, sampled every edge
//   wr_enable  in   write strobe (honoured only while ready)
//   wr_mem     in   DATA_W  write data
//   rd_mem     out  DATA_W  read data, RD_LATENCY edges after address sample
//   init_start in   request re-initialization (honoured only while ready)
//   ready      out  array initialized and accepting accesses
//   access_err out  one-cycle pulse after a write attempted while initializing
module s_memory_responder
    import s_mem_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEFAULT_ADDR_W,
    parameter int unsigned DATA_W     = DEFAULT_DATA_W,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr_mem,
    input  logic              wr_enable,
    input  logic [DATA_W-1:0] wr_mem,
    output logic [DATA_W-1:0] rd_mem,
    input  logic              init_start,
    output logic              ready,
    output logic              access_err
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    // Legal latency is 1..MAX_RD_LATENCY; out-of-range values are clamped.
    localparam int unsigned PIPE_DEPTH =
        (RD_LATENCY < 1) ? 1 :
        (RD_LATENCY > MAX_RD_LATENCY) ? MAX_RD_LATENCY : RD_LATENCY;

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    s_mem_state_e      state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              access_err_q, access_err_d;
    logic              init_we;
    logic              user_we;

    logic [DATA_W-1:0] mem [DEPTH];

    // Next-state, counter and write-strobe decode.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        init_we      = 1'b0;
        user_we      = 1'b0;
        access_err_d = 1'b0;

        unique case (state_q)
            StInit: begin
                init_we      = !reset;
                access_err_d = wr_enable;
                // Terminal compare keeps the sweep to a single pass.
                if (cnt_q == LAST_ADDR) begin
                    state_d = StReady;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StReady: begin
                user_we = wr_enable && !reset;
                // A same-edge write still commits; the new sweep overwrites it.
                if (init_start) begin
                    state_d = StInit;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StInit;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StInit;
            cnt_q        <= '0;
            access_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            access_err_q <= access_err_d;
        end
    end

    // Array contents survive reset; the init sweep rewrites them.
    always_ff @(posedge clk) begin
        if (init_we) begin
            mem[cnt_q] <= DATA_W'(cnt_q);
        end else if (user_we) begin
            mem[addr_mem] <= wr_mem;
        end
    end

    // Asynchronous array read feeds stage 1; the non-blocking array update
    // gives read-before-write on a same-address, same-edge access.
    s_mem_rd_pipe #(
        .DEPTH  (PIPE_DEPTH),
        .DATA_W (DATA_W)
    ) u_rd_pipe (
        .clk   (clk),
        .reset (reset),
        .din   (mem[addr_mem]),
        .dout  (rd_mem)
    );

    assign ready      = (state_q == StReady);
    assign access_err = access_err_q;

endmodule

// File: tb/tb_s_memory_responder.sv
// Directed bench for s_memory_responder: three instances (read latency 1, 2
// and 3) share one stimulus stream so each read is checked at every latency.
module tb_s_memory_responder;

    logic       clk;
    logic       reset;
    logic [7:0] addr_mem;
    logic       wr_enable;
    logic [7:0] wr_mem;
    logic       init_start;

    logic [7:0] rd1, rd2, rd3;
    logic       ready1, ready2, ready3;
    logic       err1, err2, err3;

    int n_tests;
    int n_fail;

    s_memory_responder #(.ADDR_W(8), .DATA_W(8), .RD_LATENCY(1)) u_dut_l1 (
        .clk        (clk),
        .reset      (reset),
        .addr_mem   (addr_mem),
        .wr_enable  (wr_enable),
        .wr_mem     (wr_mem),
        .rd_mem     (rd1),
        .init_start (init_start),
        .ready      (ready1),
        .access_err (err1)
    );

    s_memory_responder #(.ADDR_W(8), .DATA_W(8), .RD_LATENCY(2)) u_dut_l2 (
        .clk        (clk),
        .reset      (reset),
        .addr_mem   (addr_mem),
        .wr_enable  (wr_enable),
        .wr_mem     (wr_mem),
        .rd_mem     (rd2),
        .init_start (init_start),
        .ready      (ready2),
        .access_err (err2)
    );

    s_memory_responder #(.ADDR_W(8), .DATA_W(8), .RD_LATENCY(3)) u_dut_l3 (
        .clk        (clk),
        .reset      (reset),
        .addr_mem   (addr_mem),
        .wr_enable  (wr_enable),
        .wr_mem     (wr_mem),
        .rd_mem     (rd3),
        .init_start (init_start),
        .ready      (ready3),
        .access_err (err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold addr for three edges, checking each latency's output as it lands.
    task automatic read_check(input string tag, input logic [7:0] a, input logic [7:0] exp);
        addr_mem = a;
        step();
        check({tag, " lat1"}, {24'h0, rd1}, {24'h0, exp});
        step();
        check({tag, " lat2"}, {24'h0, rd2}, {24'h0, exp});
        step();
        check({tag, " lat3"}, {24'h0, rd3}, {24'h0, exp});
    endtask

    // Step until ready, bounded; reports cycles waited and any access_err seen.
    task automatic wait_ready(output int cycles, output logic saw_err);
        cycles  = 0;
        saw_err = 1'b0;
        while (!ready2 && cycles < 400) begin
            step();
            cycles++;
            if (err1 || err2 || err3) saw_err = 1'b1;
        end
    endtask

    int   cyc;
    logic saw;

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        reset      = 1'b1;
        addr_mem   = 8'h00;
        wr_enable  = 1'b0;
        wr_mem     = 8'h00;
        init_start = 1'b0;

        // 1: reset, init duration, identity contents.
        step();
        step();
        check("reset rd lat1", {24'h0, rd1}, 32'h0);
        check("reset rd lat2", {24'h0, rd2}, 32'h0);
        check("reset rd lat3", {24'h0, rd3}, 32'h0);
        check("reset ready", {31'h0, ready2}, 32'h0);
        check("reset access_err", {31'h0, err2}, 32'h0);
        reset = 1'b0;
        wait_ready(cyc, saw);
        check("init cycles", cyc, 256);
        check("ready lat1 inst", {31'h0, ready1}, 32'h1);
        check("ready lat3 inst", {31'h0, ready3}, 32'h1);
        read_check("rd 00", 8'h00, 8'h00);
        read_check("rd 7f", 8'h7F, 8'h7F);
        read_check("rd ff", 8'hFF, 8'hFF);

        // 2: write then read next cycle.
        addr_mem  = 8'h10;
        wr_mem    = 8'hA5;
        wr_enable = 1'b1;
        step();
        wr_enable = 1'b0;
        read_check("wr 10 rd", 8'h10, 8'hA5);

        // 3: same-edge read/write returns old data; next read returns new.
        addr_mem  = 8'h20;
        wr_mem    = 8'h3C;
        wr_enable = 1'b1;
        step();
        wr_enable = 1'b0;
        check("rbw old lat1", {24'h0, rd1}, 32'h20);
        step();
        check("rbw new lat1", {24'h0, rd1}, 32'h3C);
        check("rbw old lat2", {24'h0, rd2}, 32'h20);
        step();
        check("rbw new lat2", {24'h0, rd2}, 32'h3C);
        check("rbw old lat3", {24'h0, rd3}, 32'h20);
        step();
        check("rbw new lat3", {24'h0, rd3}, 32'h3C);

        // 4: re-init overwrites a user write, no access_err.
        addr_mem  = 8'h05;
        wr_mem    = 8'hEE;
        wr_enable = 1'b1;
        step();
        wr_enable  = 1'b0;
        init_start = 1'b1;
        step();
        init_start = 1'b0;
        check("reinit ready drop", {31'h0, ready2}, 32'h0);
        wait_ready(cyc, saw);
        check("reinit cycles", cyc, 256);
        check("reinit no err", {31'h0, saw}, 32'h0);
        read_check("reinit rd 05", 8'h05, 8'h05);

        // 5: write during init (after the sweep passed 0x30) is dropped.
        init_start = 1'b1;
        step();
        init_start = 1'b0;
        for (int i = 0; i < 100; i++) step();
        check("err idle in init", {31'h0, err2}, 32'h0);
        addr_mem  = 8'h30;
        wr_mem    = 8'h55;
        wr_enable = 1'b1;
        step();
        wr_enable = 1'b0;
        check("err pulse", {31'h0, err2}, 32'h1);
        check("err pulse lat3 inst", {31'h0, err3}, 32'h1);
        step();
        check("err pulse end", {31'h0, err2}, 32'h0);
        wait_ready(cyc, saw);
        check("init after err cycles", cyc, 154);
        read_check("dropped wr 30", 8'h30, 8'h30);

        // 6: reset at init cycle 100 restarts the full sweep.
        addr_mem   = 8'h44;
        init_start = 1'b1;
        step();
        init_start = 1'b0;
        for (int i = 0; i < 100; i++) step();
        reset = 1'b1;
        step();
        check("midinit reset rd lat1", {24'h0, rd1}, 32'h0);
        check("midinit reset rd lat2", {24'h0, rd2}, 32'h0);
        check("midinit reset rd lat3", {24'h0, rd3}, 32'h0);
        check("midinit reset ready", {31'h0, ready2}, 32'h0);
        step();
        reset = 1'b0;
        wait_ready(cyc, saw);
        check("restart init cycles", cyc, 256);
        read_check("post rst rd 00", 8'h00, 8'h00);
        read_check("post rst rd 7f", 8'h7F, 8'h7F);
        read_check("post rst rd ff", 8'hFF, 8'hFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
